// File: rtl/fetch_sequencer_pkg.sv
// Shared encodings and constants for the instruction-fetch sequencer.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP         = 32'h0000_0000;
    localparam int          INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_sequencer_if_id_reg.sv
// IF/ID pipeline register: flush wins over load, otherwise contents hold.
module fetch_sequencer_if_id_reg
    import fetch_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc4_in,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr <= NOP;
            pc4   <= 32'd0;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP;
            pc4   <= 32'd0;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_in;
            pc4   <= pc4_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, drives imem_addr, fills IF/ID.
// Optional FETCH_PERF_CNT_EN adds fetch/stall performance counters.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [31:0] pc,
    output logic        halted,
    output logic        fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall
`endif
);

    localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * INSTR_BYTES);
    localparam logic [31:0] PC_STEP  = 32'(INSTR_BYTES);

    fetch_state_t state, state_next;
    logic [31:0]  pc_next;
    logic [31:0]  pc_plus4;
    logic         load, flush, fault_set, out_of_range;

    assign imem_addr    = pc;
    assign pc_plus4     = pc + PC_STEP;
    assign out_of_range = (pc >= PC_LIMIT);
    assign halted       = (state == HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc    <= RESET_PC;
            fault <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (fault_set) fault <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        load       = 1'b0;
        flush      = 1'b0;
        fault_set  = 1'b0;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                // Range check precedes every other RUN action, including redirect.
                if (out_of_range) begin
                    state_next = HALT;
                    fault_set  = 1'b1;
                    flush      = 1'b1;
                end else begin
                    if (halt_req) state_next = HALT;
                    if (redirect) begin
                        pc_next = {redirect_target[31:2], 2'b00};
                        flush   = 1'b1;
                    end else if (!stall) begin
                        pc_next = pc_plus4;
                        load    = 1'b1;
                    end
                end
            end
            HALT: flush = !stall;
            default: state_next = IDLE;
        endcase
    end

    fetch_sequencer_if_id_reg u_if_id_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .flush    (flush),
        .instr_in (imem_instr),
        .pc4_in   (pc_plus4),
        .instr    (if_id_instr),
        .pc4      (if_id_pc4),
        .valid    (if_id_valid)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch <= 32'd0;
            perf_stall <= 32'd0;
        end else begin
            if (load) perf_fetch <= perf_fetch + 32'd1;
            if (state == RUN && stall && !redirect) perf_stall <= perf_stall + 32'd1;
        end
    end
`else
    // Counters absent in this build.
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench: a 64-word and a 4-word instance share one memory image.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, stall, redirect, halt_req;
    logic [31:0] redirect_target, imem_addr, imem_instr;
    logic [31:0] if_id_instr, if_id_pc4, pc;
    logic        if_id_valid, halted, fault;

    logic        s_reset, s_start;
    logic [31:0] s_imem_addr, s_imem_instr, s_if_id_instr, s_if_id_pc4, s_pc;
    logic        s_if_id_valid, s_halted, s_fault;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch, perf_stall, s_perf_fetch, s_perf_stall;
`endif

    logic [31:0] mem [0:63];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign imem_instr   = (imem_addr < 32'd256) ? mem[imem_addr[7:2]] : 32'd0;
    assign s_imem_instr = (s_imem_addr < 32'd256) ? mem[s_imem_addr[7:2]] : 32'd0;

    fetch_sequencer #(.RESET_PC(32'h0), .IMEM_WORDS(64)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .halt_req(halt_req), .imem_addr(imem_addr),
        .imem_instr(imem_instr), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid), .pc(pc), .halted(halted), .fault(fault)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch(perf_fetch), .perf_stall(perf_stall)
`endif
    );

    fetch_sequencer #(.RESET_PC(32'h0), .IMEM_WORDS(4)) dut_small (
        .clk(clk), .reset(s_reset), .start(s_start), .stall(1'b0), .redirect(1'b0),
        .redirect_target(32'd0), .halt_req(1'b0), .imem_addr(s_imem_addr),
        .imem_instr(s_imem_instr), .if_id_instr(s_if_id_instr), .if_id_pc4(s_if_id_pc4),
        .if_id_valid(s_if_id_valid), .pc(s_pc), .halted(s_halted), .fault(s_fault)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch(s_perf_fetch), .perf_stall(s_perf_stall)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'h2008_0005;
        mem[1] = 32'h2009_0003;
        mem[2] = 32'h0109_5020;
        mem[3] = 32'hAC0A_0000;

        reset = 1'b1; start = 1'b0; stall = 1'b0; redirect = 1'b0;
        halt_req = 1'b0; redirect_target = 32'd0;
        s_reset = 1'b1; s_start = 1'b0;
        step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_instr", if_id_instr, 32'h0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);

        // IDLE ignores stall/redirect; start moves to RUN without fetching
        reset = 1'b0; stall = 1'b1; redirect = 1'b1; redirect_target = 32'h40;
        step();
        chk("idle_hold_pc", pc, 32'h0);
        stall = 1'b0; redirect = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk("start_pc", pc, 32'h0);
        chk("start_valid", {31'd0, if_id_valid}, 32'd0);
        step();
        chk("f0_instr", if_id_instr, 32'h2008_0005);
        chk("f0_pc4", if_id_pc4, 32'h4);
        chk("f0_valid", {31'd0, if_id_valid}, 32'd1);
        chk("f0_pc", pc, 32'h4);
        step();
        chk("f1_instr", if_id_instr, 32'h2009_0003);
        chk("f1_pc4", if_id_pc4, 32'h8);
        chk("f1_pc", pc, 32'h8);

        stall = 1'b1;
        step();
        step();
        chk("stall_pc", pc, 32'h8);
        chk("stall_instr", if_id_instr, 32'h2009_0003);
        chk("stall_pc4", if_id_pc4, 32'h8);
        chk("stall_valid", {31'd0, if_id_valid}, 32'd1);
        stall = 1'b0;
        step();
        chk("f2_instr", if_id_instr, 32'h0109_5020);
        chk("f2_pc4", if_id_pc4, 32'hC);
        chk("f2_pc", pc, 32'hC);

        // redirect overrides stall; low target bits dropped
        stall = 1'b1; redirect = 1'b1; redirect_target = 32'h6;
        step();
        chk("redir_pc", pc, 32'h4);
        chk("redir_valid", {31'd0, if_id_valid}, 32'd0);
        chk("redir_instr", if_id_instr, 32'h0);
        chk("redir_pc4", if_id_pc4, 32'h0);
        stall = 1'b0; redirect = 1'b0;
        step();
        chk("post_redir_instr", if_id_instr, 32'h2009_0003);
        chk("post_redir_pc", pc, 32'h8);

        // back to pc=4, then halt with the fetch at 4 completing
        redirect = 1'b1; redirect_target = 32'h4;
        step();
        redirect = 1'b0;
        chk("redir4_pc", pc, 32'h4);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        chk("halt_instr", if_id_instr, 32'h2009_0003);
        chk("halt_valid", {31'd0, if_id_valid}, 32'd1);
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_pc", pc, 32'h8);
        chk("halt_nofault", {31'd0, fault}, 32'd0);
        start = 1'b1; redirect = 1'b1; redirect_target = 32'h20;
        step();
        chk("halted_pc", pc, 32'h8);
        chk("halted_flush", {31'd0, if_id_valid}, 32'd0);
        step();
        start = 1'b0; redirect = 1'b0;
        chk("halted_pc2", pc, 32'h8);
        chk("halted_still", {31'd0, halted}, 32'd1);

        // async reset between edges, mid-RUN
        reset = 1'b1;
        step();
        reset = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("rerun_pc", pc, 32'h8);
        #2 reset = 1'b1;
        #1;
        chk("async_pc", pc, 32'h0);
        chk("async_valid", {31'd0, if_id_valid}, 32'd0);
        chk("async_halted", {31'd0, halted}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("async_perf_fetch", perf_fetch, 32'd0);
        chk("async_perf_stall", perf_stall, 32'd0);
`endif
        step();
        reset = 1'b0;
        step();
        chk("async_idle_pc", pc, 32'h0);

        // 4-word memory: fetch to 12, then fault at pc=16
        s_reset = 1'b0; s_start = 1'b1;
        step();
        s_start = 1'b0;
        step();
        step();
        step();
        chk("small_pc12", s_pc, 32'hC);
        step();
        chk("small_pc16", s_pc, 32'h10);
        chk("small_instr3", s_if_id_instr, 32'hAC0A_0000);
        chk("small_halted0", {31'd0, s_halted}, 32'd0);
        step();
        chk("small_fault", {31'd0, s_fault}, 32'd1);
        chk("small_halted", {31'd0, s_halted}, 32'd1);
        chk("small_valid", {31'd0, s_if_id_valid}, 32'd0);
        chk("small_pc_frz", s_pc, 32'h10);
        step();
        chk("small_pc_frz2", s_pc, 32'h10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
